// File: rtl/recirc_rr_arbiter_if.sv
// Lane-FIFO side bundle of the recirculation arbiter: FIFO status/heads in, pops and forwarded byte out.
// master = arbiter, slave = lane FIFOs / downstream mux environment.
interface recirc_rr_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int TH_WIDTH   = 3
);
  logic                  init;
  logic [TH_WIDTH-1:0]   umbral_alto_in;
  logic [TH_WIDTH-1:0]   umbral_bajo_in;
  logic [3:0]            fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data0;
  logic [DATA_WIDTH-1:0] fifo_data1;
  logic [DATA_WIDTH-1:0] fifo_data2;
  logic [DATA_WIDTH-1:0] fifo_data3;
  logic                  down_almost_full;
  logic                  error_in;
  logic [3:0]            pop;
  logic [1:0]            selector;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic [TH_WIDTH-1:0]   umbral_alto;
  logic [TH_WIDTH-1:0]   umbral_bajo;
  logic [2:0]            estado;
  logic                  idle;
  logic                  error_out;

  modport master (
    input  init, umbral_alto_in, umbral_bajo_in, fifo_empty,
           fifo_data0, fifo_data1, fifo_data2, fifo_data3,
           down_almost_full, error_in,
    output pop, selector, data_out, valid_out, umbral_alto, umbral_bajo,
           estado, idle, error_out
  );

  modport slave (
    output init, umbral_alto_in, umbral_bajo_in, fifo_empty,
           fifo_data0, fifo_data1, fifo_data2, fifo_data3,
           down_almost_full, error_in,
    input  pop, selector, data_out, valid_out, umbral_alto, umbral_bajo,
           estado, idle, error_out
  );
endinterface

// File: rtl/recirc_rr_arbiter.sv
// Round-robin 4-lane pop scheduler for the recirculation mux; pop is same-cycle, data/valid/selector 1 cycle later.
// down_almost_full blocks pop combinationally; any FIFO fault parks the block in a sticky ERROR state.
module recirc_rr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int TH_WIDTH   = 3
) (
  input  logic               clk,
  input  logic               reset_L,
  recirc_rr_arbiter_if.master bus
);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            ptr_q, ptr_d;
  logic [1:0]            sel_q, sel_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic [TH_WIDTH-1:0]   alto_q, alto_d;
  logic [TH_WIDTH-1:0]   bajo_q, bajo_d;
  logic                  idle_q, idle_d;
  logic                  err_q, err_d;

  logic                  grant_en;
  logic                  grant_vld;
  logic [1:0]            grant_idx;
  logic [DATA_WIDTH-1:0] grant_dat;
  logic [3:0]            pop;

  assign grant_en = (state_q == ST_ACTIVE) && !bus.down_almost_full &&
                    !bus.init && !bus.error_in;

  // First non-empty lane at or after ptr; a lane empty this cycle is never popped.
  always_comb begin
    logic [1:0] cand;
    grant_vld = 1'b0;
    grant_idx = ptr_q;
    cand      = ptr_q;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (grant_en && !grant_vld && !bus.fifo_empty[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    case (grant_idx)
      2'd0:    grant_dat = bus.fifo_data0;
      2'd1:    grant_dat = bus.fifo_data1;
      2'd2:    grant_dat = bus.fifo_data2;
      default: grant_dat = bus.fifo_data3;
    endcase
  end

  assign pop = grant_vld ? (4'b0001 << grant_idx) : 4'b0000;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    data_d  = data_q;
    valid_d = grant_vld;
    alto_d  = alto_q;
    bajo_d  = bajo_q;

    if (grant_vld) begin
      sel_d  = grant_idx;
      data_d = grant_dat;
      ptr_d  = grant_idx + 2'd1;
    end

    if (state_q == ST_INIT) begin
      alto_d = bus.umbral_alto_in;
      bajo_d = bus.umbral_bajo_in;
    end

    // Fault beats re-init, re-init beats the normal flow; RESET ignores both.
    case (state_q)
      ST_RESET: state_d = ST_INIT;
      ST_ERROR: state_d = ST_ERROR;
      default: begin
        if (bus.error_in) begin
          state_d = ST_ERROR;
        end else if (bus.init) begin
          state_d = ST_INIT;
        end else begin
          case (state_q)
            ST_INIT:   state_d = ST_IDLE;
            ST_IDLE:   state_d = (bus.fifo_empty != 4'b1111) ? ST_ACTIVE : ST_IDLE;
            ST_ACTIVE: state_d = (bus.fifo_empty == 4'b1111) ? ST_IDLE : ST_ACTIVE;
            default:   state_d = ST_ERROR;
          endcase
        end
      end
    endcase

    idle_d = (state_d == ST_IDLE);
    err_d  = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= ST_RESET;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      data_q  <= '0;
      valid_q <= 1'b0;
      alto_q  <= '0;
      bajo_q  <= '0;
      idle_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      alto_q  <= alto_d;
      bajo_q  <= bajo_d;
      idle_q  <= idle_d;
      err_q   <= err_d;
    end
  end

  assign bus.pop         = pop;
  assign bus.selector    = sel_q;
  assign bus.data_out    = data_q;
  assign bus.valid_out   = valid_q;
  assign bus.umbral_alto = alto_q;
  assign bus.umbral_bajo = bajo_q;
  assign bus.estado      = state_q;
  assign bus.idle        = idle_q;
  assign bus.error_out   = err_q;

endmodule

// File: tb/tb_recirc_rr_arbiter.sv
// Directed + randomized bench for recirc_rr_arbiter against a cycle-level behavioural model.
module tb_recirc_rr_arbiter;
  localparam int DW = 8;
  localparam int TW = 3;

  logic clk = 1'b0;
  logic reset_L = 1'b0;
  always #5 clk = ~clk;

  recirc_rr_arbiter_if #(.DATA_WIDTH(DW), .TH_WIDTH(TW)) bus ();
  recirc_rr_arbiter #(.DATA_WIDTH(DW), .TH_WIDTH(TW)) dut (
    .clk(clk), .reset_L(reset_L), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // stimulus
  logic          t_init, t_daf, t_err;
  logic [3:0]    t_emp;
  logic [TW-1:0] t_alto, t_bajo;
  logic [DW-1:0] fd [4];

  // model
  int            m_st, m_ptr, m_sel, m_g;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic [TW-1:0] m_alto, m_bajo;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    bus.init             = t_init;
    bus.down_almost_full = t_daf;
    bus.error_in         = t_err;
    bus.fifo_empty       = t_emp;
    bus.umbral_alto_in   = t_alto;
    bus.umbral_bajo_in   = t_bajo;
    bus.fifo_data0       = fd[0];
    bus.fifo_data1       = fd[1];
    bus.fifo_data2       = fd[2];
    bus.fifo_data3       = fd[3];
  endtask

  task automatic model_reset();
    m_st = 0; m_ptr = 0; m_sel = 0; m_data = '0; m_valid = 1'b0;
    m_alto = '0; m_bajo = '0; m_g = -1;
  endtask

  // Lane the model would serve this cycle, or -1.
  task automatic model_grant();
    m_g = -1;
    if (reset_L && m_st == 3 && !t_daf && !t_init && !t_err)
      for (int k = 0; k < 4; k++)
        if (m_g < 0 && !t_emp[(m_ptr + k) % 4]) m_g = (m_ptr + k) % 4;
  endtask

  task automatic model_edge();
    int nxt;
    if (!reset_L) begin
      model_reset();
      return;
    end
    if (m_st == 1) begin m_alto = t_alto; m_bajo = t_bajo; end
    if (m_g >= 0) begin
      m_data = fd[m_g]; m_sel = m_g; m_valid = 1'b1; m_ptr = (m_g + 1) % 4;
    end else begin
      m_valid = 1'b0;
    end
    if (m_st == 0)      nxt = 1;
    else if (m_st == 4) nxt = 4;
    else if (t_err)     nxt = 4;
    else if (t_init)    nxt = 1;
    else if (m_st == 1) nxt = 2;
    else if (m_st == 2) nxt = (t_emp != 4'hF) ? 3 : 2;
    else                nxt = (t_emp == 4'hF) ? 2 : 3;
    m_st = nxt;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".estado"},    32'(bus.estado),      32'(m_st));
    chk({tag, ".valid_out"}, 32'(bus.valid_out),   32'(m_valid));
    chk({tag, ".data_out"},  32'(bus.data_out),    32'(m_data));
    chk({tag, ".selector"},  32'(bus.selector),    32'(m_sel));
    chk({tag, ".idle"},      32'(bus.idle),        32'(m_st == 2));
    chk({tag, ".error_out"}, 32'(bus.error_out),   32'(m_st == 4));
    chk({tag, ".alto"},      32'(bus.umbral_alto), 32'(m_alto));
    chk({tag, ".bajo"},      32'(bus.umbral_bajo), 32'(m_bajo));
  endtask

  // Called at a negedge: drive, check same-cycle pop, clock, check registered outputs.
  task automatic tick(input string tag);
    logic [3:0] exp_pop;
    apply();
    #1;
    model_grant();
    exp_pop = (m_g >= 0) ? (4'b0001 << m_g) : 4'b0000;
    chk({tag, ".pop"}, 32'(bus.pop), 32'(exp_pop));
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
    @(negedge clk);
  endtask

  task automatic set_in(input logic init, input logic [3:0] emp, input logic daf, input logic err);
    t_init = init; t_emp = emp; t_daf = daf; t_err = err;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    fd[0] = 8'hA0; fd[1] = 8'hB1; fd[2] = 8'hC2; fd[3] = 8'hD3;
    t_alto = 3'd6; t_bajo = 3'd1;
    set_in(1'b1, 4'b0000, 1'b0, 1'b0);

    // Reset held with busy inputs: everything zero.
    reset_L = 1'b0;
    @(negedge clk);
    tick("rst_hold");
    tick("rst_hold2");

    // Release into INIT, load thresholds, drop init.
    reset_L = 1'b1;
    tick("rst_to_init");
    tick("init_load");
    set_in(1'b0, 4'b1111, 1'b0, 1'b0);
    tick("init_to_idle");

    // All four lanes full.
    set_in(1'b0, 4'b0000, 1'b0, 1'b0);
    tick("idle_to_active");
    for (int i = 0; i < 5; i++) tick("rr_full");

    // Steer ptr to 2, then only lanes 1 and 3 populated.
    set_in(1'b0, 4'b1101, 1'b0, 1'b0);
    tick("ptr_to_2");
    chk("ptr2_sel", 32'(bus.selector), 32'd1);
    set_in(1'b0, 4'b0101, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick("skip_empty");
    chk("skip_last_sel", 32'(bus.selector), 32'd3);
    set_in(1'b0, 4'b1111, 1'b0, 1'b0);
    tick("all_empty");

    // Back-pressure for 3 cycles mid-stream.
    set_in(1'b0, 4'b0000, 1'b0, 1'b0);
    tick("bp_wake");
    tick("bp_pre0");
    tick("bp_pre1");
    t_daf = 1'b1;
    for (int i = 0; i < 3; i++) tick("bp_hold");
    t_daf = 1'b0;
    for (int i = 0; i < 3; i++) tick("bp_resume");

    // Re-init mid-operation with new thresholds.
    t_alto = 3'd5; t_bajo = 3'd2;
    set_in(1'b1, 4'b0000, 1'b0, 1'b0);
    tick("reinit_enter");
    tick("reinit_load");
    set_in(1'b0, 4'b0000, 1'b0, 1'b0);
    tick("reinit_idle");
    tick("reinit_active");
    for (int i = 0; i < 4; i++) tick("reinit_rr");

    // Randomized traffic, no faults.
    for (int i = 0; i < 400; i++) begin
      t_emp  = 4'($urandom);
      t_daf  = ($urandom_range(3) == 0);
      t_init = ($urandom_range(24) == 0);
      t_err  = 1'b0;
      t_alto = 3'($urandom);
      t_bajo = 3'($urandom);
      for (int l = 0; l < 4; l++) fd[l] = 8'($urandom);
      tick("random");
    end

    // Async reset while a valid byte is pending.
    set_in(1'b0, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick("pre_async");
    #2;
    reset_L = 1'b0;
    #1;
    model_reset();
    chk("async.pop", 32'(bus.pop), 32'd0);
    check_outputs("async_rst");
    @(negedge clk);
    reset_L = 1'b1;
    t_alto = 3'd3; t_bajo = 3'd4;
    set_in(1'b1, 4'b0000, 1'b0, 1'b0);
    tick("re_rst_init");
    tick("re_rst_load");
    set_in(1'b0, 4'b0000, 1'b0, 1'b0);
    tick("re_rst_idle");
    tick("re_rst_active");
    tick("re_rst_rr");

    // Fault pulse together with init: ERROR wins and is sticky.
    set_in(1'b1, 4'b0000, 1'b0, 1'b1);
    tick("err_pulse");
    set_in(1'b1, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick("err_sticky");
    set_in(1'b0, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) tick("err_sticky2");
    chk("err_estado", 32'(bus.estado), 32'd4);
    reset_L = 1'b0;
    tick("err_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/recirc_rr_arbiter.md
# recirc_rr_arbiter

Round-robin scheduler that shares the single downstream 4:1 lane mux of the recirculation path among four lane input FIFOs. Each cycle it picks one non-empty lane, pops it, and forwards the byte with a valid flag and the mux selector. It also holds the FIFO almost-full/almost-empty thresholds loaded during initialization. It honours downstream back-pressure and goes to a sticky error state on any FIFO fault.

## Interface
- DATA_WIDTH, 8, lane data width
- TH_WIDTH, 3, threshold width

- clk  in  1  system clock, rising edge
- reset_L  in  1  asynchronous, active-low reset
- init  in  1  high = enter/stay in INIT and load thresholds
- umbral_alto_in  in  TH_WIDTH  almost-full threshold to load
- umbral_bajo_in  in  TH_WIDTH  almost-empty threshold to load
- fifo_empty  in  4  empty flag per lane; bit i = lane i
- fifo_data0..fifo_data3  in  DATA_WIDTH  show-ahead head of lane FIFO (valid when not empty)
- down_almost_full  in  1  downstream FIFO back-pressure
- error_in  in  1  OR of lane FIFO overflow/underflow
- pop  out  4  one-hot pop strobe to lane FIFOs
- selector  out  2  registered lane index of data_out
- data_out  out  DATA_WIDTH  registered forwarded byte
- valid_out  out  1  registered, data_out valid
- umbral_alto  out  TH_WIDTH  configured almost-full threshold
- umbral_bajo  out  TH_WIDTH  configured almost-empty threshold
- estado  out  3  current state: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4
- idle  out  1  high in IDLE
- error_out  out  1  high in ERROR

## Operation
- **reset_L low:** asynchronously forces the following, all held while reset_L is low:
  - estado=RESET, round-robin pointer ptr=0
  - pop=0, selector=0, data_out=0, valid_out=0
  - thresholds=0, idle=0, error_out=0
- **Transition priority:** error_in > init > normal transitions. error_in high in any state other than RESET goes to ERROR next edge.
- **RESET:** goes to INIT on the first edge with reset_L high.
- **INIT:**
  - umbral_alto/umbral_bajo register the *_in values on every edge while in INIT.
  - Stays in INIT while init=1; goes to IDLE when init=0.
- **IDLE:**
  - idle=1.
  - Goes to ACTIVE when any fifo_empty bit is 0.
  - init=1 goes to INIT.
- **ACTIVE:**
  - Grant is combinational. It is enabled only when down_almost_full=0, init=0 and error_in=0.
  - The granted lane is the first lane with fifo_empty=0, searching ptr, ptr+1, ptr+2, ptr+3 mod 4.
  - pop = one-hot of the granted lane, in the same cycle.
  - On a grant, at the next edge: data_out=fifo_dataG, selector=G, valid_out=1, ptr=(G+1) mod 4 (3 wraps to 0).
  - With no grant: valid_out=0 next edge; data_out and selector hold; ptr holds.
  - Goes to IDLE on an edge where fifo_empty=4'b1111.
  - init=1 goes to INIT; thresholds keep their values until reloaded.
- **ERROR:**
  - Sticky; left only via reset_L.
  - pop=0, valid_out=0, error_out=1; data_out and selector hold.
- **pop** is 0 in every state other than ACTIVE. At most one pop bit is ever high.

## Timing
- Latency from pop(lane i) at cycle N to data_out/valid_out/selector at cycle N+1 is 1 cycle.
- Throughput is one byte per cycle while lanes are non-empty and there is no back-pressure.
- IDLE to ACTIVE costs one cycle; the first pop happens in the first ACTIVE cycle.
- down_almost_full is sampled combinationally. Setting it high blocks pop in the same cycle; valid_out drops the next cycle.
- A lane becoming empty in the same cycle it is considered is skipped. The arbiter never pops an empty lane.
- Simultaneous init and error_in: ERROR wins.
- Reset mid-ACTIVE clears all outputs immediately (asynchronously), including a pending valid_out.
- Thresholds are never changed outside INIT.

## Test plan
- **Reset:** hold reset_L=0 with active inputs -> every output 0, estado=0. Release reset_L with init=1, umbral_alto_in=6, umbral_bajo_in=1 -> estado=1, then umbral_alto=6, umbral_bajo=1. Drop init -> estado=2, idle=1.
- **Round robin, all lanes full:** all four lanes non-empty with data A0/B1/C2/D3, no back-pressure -> pop sequence 0001, 0010, 0100, 1000, 0001. data_out A0, B1, C2, D3 each one cycle later, with selector 0, 1, 2, 3 and valid_out=1.
- **Skipping empty lanes:** only lanes 1 and 3 non-empty, ptr=2 -> grants 3, 1, 3. Then all empty -> valid_out=0 and estado returns to 2.
- **Back-pressure:** down_almost_full=1 for 3 cycles mid-stream -> pop=0 for those cycles and valid_out=0 one cycle later. On release, service resumes at the saved ptr lane.
- **Error:** error_in pulsed for one cycle in ACTIVE -> estado=4, error_out=1, pop=0 permanently, even with init=1. Only reset_L=0 returns estado to 0.
- **Re-init mid-operation:** init=1 in ACTIVE -> estado=1, pop=0. New thresholds 5/2 load, old values hold until the first INIT edge. Drop init -> IDLE, then ACTIVE resumes round robin from the retained ptr.
